// File: rtl/uart_bus_master.sv
// ============================================================================
// Module   : uart_bus_master
// Purpose  : UART-driven debug/loader initiator. Parses W/R/P command frames
//            from RX, issues one bus access per frame, and replies on TX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_master #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [31:0]           o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_wr_valid,
    input  logic                  i_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_rd_valid,
    output logic                  o_rd_ready,
    output logic                  o_busy,
    output logic                  o_bus_err
);

    localparam int c_nb    = DATA_WIDTH / 8;
    localparam int c_tmo_w = $clog2(TIMEOUT + 1);
    localparam int c_cnt_w = $clog2(c_nb + 4) + 1;

    localparam logic [7:0] c_op_write = 8'h57;
    localparam logic [7:0] c_op_read  = 8'h52;
    localparam logic [7:0] c_op_ping  = 8'h50;
    localparam logic [7:0] c_ack      = 8'h06;
    localparam logic [7:0] c_nak      = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_BUS_WR = 3'd3,
        S_BUS_RD = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              op_q, op_d;
    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    logic [c_tmo_w-1:0]      tmo_q, tmo_d;
    logic [31:0]             addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic                    bus_err_q, bus_err_d;

    logic                    w_rx_ready;
    logic                    w_rx_fire;
    logic                    w_tmo_hit;

    assign w_rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign w_rx_fire  = w_rx_ready && i_rx_valid;
    assign w_tmo_hit  = (tmo_q == c_tmo_w'(TIMEOUT));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            op_q      <= 8'h00;
            cnt_q     <= '0;
            tmo_q     <= '0;
            addr_q    <= 32'h0;
            data_q    <= '0;
            tx_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        data_d    = data_q;
        tx_d      = tx_q;
        bus_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_rx_fire) begin
                    op_d  = i_rx_data;
                    cnt_d = '0;
                    // Single-byte replies sit in the top byte of the TX shifter
                    if (i_rx_data == c_op_write || i_rx_data == c_op_read) begin
                        state_d = S_ADDR;
                    end else if (i_rx_data == c_op_ping) begin
                        tx_d    = DATA_WIDTH'(c_op_ping) << (DATA_WIDTH - 8);
                        state_d = S_RESP;
                    end else begin
                        tx_d    = DATA_WIDTH'(c_nak) << (DATA_WIDTH - 8);
                        state_d = S_RESP;
                    end
                end
            end

            S_ADDR: begin
                if (w_rx_fire) begin
                    addr_d = {addr_q[23:0], i_rx_data};
                    cnt_d  = cnt_q + c_cnt_w'(1);
                    if (cnt_q == c_cnt_w'(3)) begin
                        cnt_d   = '0;
                        tmo_d   = '0;
                        state_d = (op_q == c_op_write) ? S_DATA : S_BUS_RD;
                    end
                end
            end

            S_DATA: begin
                if (w_rx_fire) begin
                    data_d = (data_q << 8) | DATA_WIDTH'(i_rx_data);
                    cnt_d  = cnt_q + c_cnt_w'(1);
                    if (cnt_q == c_cnt_w'(c_nb - 1)) begin
                        cnt_d   = '0;
                        tmo_d   = '0;
                        state_d = S_BUS_WR;
                    end
                end
            end

            S_BUS_WR: begin
                // A grant on the final counted cycle still wins over the timeout
                if (i_wr_ready) begin
                    tx_d    = DATA_WIDTH'(c_ack) << (DATA_WIDTH - 8);
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (w_tmo_hit) begin
                    tx_d      = DATA_WIDTH'(c_nak) << (DATA_WIDTH - 8);
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + c_tmo_w'(1);
                end
            end

            S_BUS_RD: begin
                if (i_rd_valid) begin
                    tx_d    = i_data;
                    cnt_d   = c_cnt_w'(c_nb - 1);
                    state_d = S_RESP;
                end else if (w_tmo_hit) begin
                    tx_d      = DATA_WIDTH'(c_nak) << (DATA_WIDTH - 8);
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + c_tmo_w'(1);
                end
            end

            S_RESP: begin
                // cnt_q holds the number of bytes still to send after this one
                if (i_tx_ready) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - c_cnt_w'(1);
                        tx_d  = tx_q << 8;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign o_rx_ready = w_rx_ready && !i_rst;
    assign o_tx_valid = (state_q == S_RESP);
    assign o_tx_data  = (state_q == S_RESP) ? tx_q[DATA_WIDTH-1 -: 8] : 8'h00;
    assign o_addr     = addr_q;
    assign o_data     = data_q;
    assign o_wr_valid = (state_q == S_BUS_WR);
    assign o_rd_ready = (state_q == S_BUS_RD);
    assign o_busy     = (state_q != S_IDLE);
    assign o_bus_err  = bus_err_q;

endmodule

`default_nettype wire
